pot_scan_sched: RTL and testbench
=================================

POT_SCAN_SCHED -- requirements
Module: pot_scan_sched

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 16'd50000, cycles between sweep requests (legal 2..65535).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port en  input  1  scanning enable.
REQ-005 SHALL have port ch_mask  input  8  channel enable mask, bit i selects channel i.
REQ-006 SHALL have port strt_cnv  output  1  one-cycle conversion start pulse to the A2D interface.
REQ-007 SHALL have port chnnl  output  3  channel number presented to the A2D interface.
REQ-008 SHALL have port cnv_cmplt  input  1  A2D completion level, held high until the next strt_cnv.
REQ-009 SHALL have port res  input  12  A2D result, valid while cnv_cmplt is high.
REQ-010 SHALL have port rd_ch  input  3  read-port channel select.
REQ-011 SHALL have port rd_data  output  12  stored value of channel rd_ch, combinational.
REQ-012 SHALL have port ch_vld  output  8  bit i high once channel i holds a sample.
REQ-013 SHALL have port sweep_done  output  1  one-cycle pulse at end of each sweep.

Function
REQ-014 SHALL run a 16-bit down-counter every cycle: reload SCAN_PERIOD-1 on reaching 0, set sweep-pending flag on that expiry.
REQ-015 SHALL implement states IDLE, START, GUARD, CONV, STORE.
REQ-016 IDLE -> START when en, pending flag and ch_mask!=0; pending cleared, cur = lowest set bit of ch_mask; otherwise remain in IDLE.
REQ-017 START: strt_cnv=1 for exactly one cycle, chnnl=cur; -> GUARD.
REQ-018 GUARD: one cycle, cnv_cmplt ignored (stale high from previous conversion); -> CONV.
REQ-019 CONV: wait for cnv_cmplt=1; -> STORE; no timeout.
REQ-020 STORE: write res to register cur, set ch_vld[cur]; next = lowest set bit of ch_mask above cur.
REQ-021 STORE: if next exists and en=1 -> START with cur=next; else sweep_done=1 that cycle, -> IDLE.
REQ-022 chnnl SHALL hold cur steady from START through STORE.
REQ-023 en deasserted during START/GUARD/CONV SHALL NOT abort; the conversion completes and stores, then IDLE, sweep_done pulses.
REQ-024 ch_mask SHALL be sampled only in IDLE (first channel) and STORE (next channel); changes mid-conversion take effect at the next STORE.
REQ-025 Timer expiry during a sweep SHALL set pending; new sweep starts immediately on IDLE entry + 1 cycle; multiple expiries collapse into one pending.
REQ-026 rd_data SHALL be 12'h000 for channels with ch_vld=0.

Reset
REQ-027 rst high SHALL asynchronously force: state IDLE, strt_cnv 0, chnnl 0, sweep_done 0, ch_vld 0, all value registers 0, timer SCAN_PERIOD-1, pending 0.
REQ-028 rst mid-conversion SHALL discard the conversion; after release, first sweep follows the first timer expiry.

Configuration
REQ-029 Macro POT_IIR_EN defined: STORE writes old + ((res - old) >>> 2), computed signed 14-bit, truncated to 12 bits; first sample (ch_vld=0) loads res directly.
REQ-030 POT_IIR_EN undefined: STORE writes res directly; no filter logic synthesized.

Structure
REQ-031 Package pot_scan_pkg SHALL hold NUM_CH=8, RES_W=12, and state_t enum.
REQ-032 Sub-module nxt_ch_sel SHALL be combinational: inputs mask, cur, first-flag; outputs next index and found bit.

Verification
REQ-033 SCAN_PERIOD=20, mask=8'h05, en=1, A2D model returns 12'h123/12'h456 -> strt_cnv with chnnl 0 then 2, ch_vld=8'h05, rd_data(2)=12'h456, one sweep_done.
REQ-034 mask=8'h00, en=1 for 100 cycles -> strt_cnv never asserts, sweep_done never pulses.
REQ-035 cnv_cmplt held high from prior conversion -> no STORE before GUARD; store occurs only after model re-raises cnv_cmplt.
REQ-036 Drop en during channel 0 conversion of mask 8'h03 -> channel 0 stored, channel 1 not started, sweep_done pulses once.
REQ-037 Assert rst during CONV -> strt_cnv 0, ch_vld 8'h00, rd_data 0 same cycle; no sweep until timer expires after release.
REQ-038 POT_IIR_EN defined: samples 12'h400 then 12'h800 on channel 3 -> rd_data(3) 12'h400 then 12'h500.

Source files
------------

// File: rtl/pot_scan_pkg.sv
// Shared constants and FSM state type for the potentiometer scan scheduler.
package pot_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned RES_W  = 12;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GUARD,
    CONV,
    STORE
  } state_t;

endpackage

// File: rtl/nxt_ch_sel.sv
// Combinational next-channel picker: lowest set mask bit, either overall (first)
// or strictly above the current channel.
module nxt_ch_sel
  import pot_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   nxt,
  output logic              found
);

  logic [CH_W-1:0] idx;

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = '0;
    // walk from the top down so the lowest qualifying index is written last
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = CH_W'(NUM_CH - 1 - i);
      if (mask[idx] && (first || (idx > cur))) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pot_scan_sched.sv
// Periodic A2D sweep scheduler over a masked set of channels with per-channel
// result registers. Define POT_IIR_EN to store a 1/4-weight IIR-filtered value.
module pot_scan_sched
  import pot_scan_pkg::*;
#(
  parameter logic [15:0] SCAN_PERIOD = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic                 strt_cnv,
  output logic [CH_W-1:0]      chnnl,
  input  logic                 cnv_cmplt,
  input  logic [RES_W-1:0]     res,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [RES_W-1:0]     rd_data,
  output logic [NUM_CH-1:0]    ch_vld,
  output logic                 sweep_done
);

  state_t            state;
  logic [15:0]       tmr;
  logic              pending;
  logic [CH_W-1:0]   cur;
  logic [RES_W-1:0]  val [NUM_CH];
  logic [RES_W-1:0]  store_val;
  logic [CH_W-1:0]   nxt;
  logic              found;
  logic              first_sel;
  logic              start_sweep;

  assign first_sel   = (state == IDLE);
  assign start_sweep = (state == IDLE) && en && pending && found;

  nxt_ch_sel u_nxt_ch_sel (
    .mask  (ch_mask),
    .cur   (cur),
    .first (first_sel),
    .nxt   (nxt),
    .found (found)
  );

`ifdef POT_IIR_EN
  logic signed [RES_W+1:0] diff;
  logic signed [RES_W+1:0] filt;

  always_comb begin
    diff      = $signed({2'b00, res}) - $signed({2'b00, val[cur]});
    filt      = $signed({2'b00, val[cur]}) + (diff >>> 2);
    store_val = ch_vld[cur] ? filt[RES_W-1:0] : res;
  end
`else
  assign store_val = res;
`endif

  // A fresh expiry outranks the clear so a request landing on sweep start is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr     <= SCAN_PERIOD - 16'd1;
      pending <= 1'b0;
    end else begin
      if (tmr == '0) begin
        tmr     <= SCAN_PERIOD - 16'd1;
        pending <= 1'b1;
      end else begin
        tmr <= tmr - 16'd1;
        if (start_sweep) pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      cur        <= '0;
      sweep_done <= 1'b0;
      ch_vld     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) val[i] <= '0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_sweep) begin
            cur      <= nxt;
            chnnl    <= nxt;
            strt_cnv <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          strt_cnv <= 1'b0;
          state    <= GUARD;
        end
        GUARD: state <= CONV;
        CONV: begin
          if (cnv_cmplt) state <= STORE;
        end
        STORE: begin
          val[cur]    <= store_val;
          ch_vld[cur] <= 1'b1;
          if (found && en) begin
            cur      <= nxt;
            chnnl    <= nxt;
            strt_cnv <= 1'b1;
            state    <= START;
          end else begin
            sweep_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = ch_vld[rd_ch] ? val[rd_ch] : '0;

endmodule

// File: tb/tb_pot_scan_sched.sv
// Randomized bench for pot_scan_sched: A2D responder plus a transaction-level
// model of expected channel order and stored values.
module tb_pot_scan_sched;

  localparam logic [15:0] PERIOD = 16'd20;
`ifdef POT_IIR_EN
  localparam bit IIR = 1'b1;
`else
  localparam bit IIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  ch_mask;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [7:0]  ch_vld;
  logic        sweep_done;

  always #5 clk = ~clk;

  pot_scan_sched #(.SCAN_PERIOD(PERIOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_mask    (ch_mask),
    .strt_cnv   (strt_cnv),
    .chnnl      (chnnl),
    .cnv_cmplt  (cnv_cmplt),
    .res        (res),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .ch_vld     (ch_vld),
    .sweep_done (sweep_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: what each channel register should hold after the sweeps so far.
  logic [11:0] exp_val [8];
  logic [7:0]  exp_vld;
  int          q_res[$];
  int          start_log[$];
  int          strt_count = 0;
  int          sd_count   = 0;
  int          dbl_pulse  = 0;

  function automatic logic [11:0] next_val(input logic [11:0] old, input logic [11:0] r,
                                           input logic vld);
    int o;
    int d;
    if (!IIR || !vld) return r;
    o = int'(old);
    d = int'(r) - o;
    return 12'(o + (d >>> 2));
  endfunction

  initial begin : pulse_monitor
    logic prev_strt;
    logic prev_sd;
    prev_strt = 1'b0;
    prev_sd   = 1'b0;
    forever begin
      @(negedge clk);
      if (strt_cnv) strt_count++;
      if (sweep_done) sd_count++;
      if ((strt_cnv && prev_strt) || (sweep_done && prev_sd)) dbl_pulse++;
      prev_strt = strt_cnv;
      prev_sd   = sweep_done;
    end
  end

  // A2D responder: leaves the previous completion high through the cycle after
  // the start pulse, then drops it and returns a result a few cycles later.
  initial begin : a2d_model
    int phase;
    int cnt;
    int a_ch;
    phase = 0;
    cnt   = 0;
    a_ch  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase     = 0;
        cnv_cmplt = 1'b0;
      end else begin
        case (phase)
          0: if (strt_cnv) begin
            a_ch = int'(chnnl);
            start_log.push_back(a_ch);
            phase = 1;
          end
          1: begin
            cnv_cmplt = 1'b0;
            cnt       = $urandom_range(1, 6);
            phase     = 2;
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              res = (q_res.size() > 0) ? 12'(q_res.pop_front()) : 12'($urandom);
              cnv_cmplt = 1'b1;
              chk("chnnl_hold", chnnl, a_ch);
              exp_val[a_ch] = next_val(exp_val[a_ch], res, exp_vld[a_ch]);
              exp_vld[a_ch] = 1'b1;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_vld = '0;
    for (int i = 0; i < 8; i++) exp_val[i] = '0;
    q_res.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_evt(input string tag, input bit on_sd, input int budget);
    int base;
    int n;
    base = on_sd ? sd_count : strt_count;
    n = 0;
    while (((on_sd ? sd_count : strt_count) == base) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, ((on_sd ? sd_count : strt_count) != base), 1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] m, input int q[$]);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        chk($sformatf("%s_ch%0d", tag, k), (k < q.size()) ? q[k] : 99, i);
        k++;
      end
    end
    chk({tag, "_len"}, q.size(), k);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_vld"}, ch_vld, exp_vld);
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), rd_data, exp_val[i]);
    end
  endtask

  initial begin : main
    int s0;
    int d0;
    int n;
    int got[$];
    logic [7:0] m;
    logic [7:0] m_next;

    rst = 1'b1; en = 1'b0; ch_mask = '0; rd_ch = '0; cnv_cmplt = 1'b0; res = '0;
    clear_model();
    tick();
    chk("rst_strt", strt_cnv, 0);
    chk("rst_sd", sweep_done, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_vld", ch_vld, 0);
    chk("rst_rd", rd_data, 0);
    do_reset();

    // Empty mask: timer keeps expiring but nothing is ever started.
    en = 1'b1;
    s0 = strt_count;
    d0 = sd_count;
    repeat (100) tick();
    chk("mask0_strt", strt_count - s0, 0);
    chk("mask0_sd", sd_count - d0, 0);

    // Two-channel sweep with fixed results; a stale-completion store would put 123 in ch2.
    q_res = '{12'h123, 12'h456};
    start_log.delete();
    d0 = sd_count;
    ch_mask = 8'h05;
    wait_evt("s33_done", 1'b1, 400);
    en = 1'b0;
    got = start_log;
    check_seq("s33_seq", 8'h05, got);
    chk("s33_vld", ch_vld, 8'h05);
    rd_ch = 3'd2; #1; chk("s33_rd2", rd_data, 12'h456);
    rd_ch = 3'd0; #1; chk("s33_rd0", rd_data, 12'h123);
    repeat (50) tick();
    chk("s33_one_sweep", sd_count - d0, 1);

    // Reset in the middle of a conversion, then the first sweep waits on the timer.
    en = 1'b1;
    wait_evt("s37_start", 1'b0, 100);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("s37_strt", strt_cnv, 0);
    chk("s37_vld", ch_vld, 0);
    rd_ch = 3'd2; #1; chk("s37_rd2", rd_data, 0);
    clear_model();
    tick();
    tick();
    start_log.delete();
    rst = 1'b0;
    n = 0;
    while (!strt_cnv && (n < 100)) begin
      tick();
      n++;
    end
    chk("s37_first_delay", (n >= int'(PERIOD)) && (n <= int'(PERIOD) + 2), 1);
    wait_evt("s37_done", 1'b1, 400);
    got = start_log;
    check_seq("s37_seq", 8'h05, got);
    check_all("s37");

    // Dropping enable during the first conversion finishes only that channel.
    do_reset();
    start_log.delete();
    ch_mask = 8'h03;
    en = 1'b1;
    d0 = sd_count;
    wait_evt("s36_start", 1'b0, 100);
    en = 1'b0;
    wait_evt("s36_done", 1'b1, 100);
    repeat (30) tick();
    got = start_log;
    check_seq("s36_seq", 8'h01, got);
    chk("s36_one_sweep", sd_count - d0, 1);
    check_all("s36");

    // Random masks and results over back-to-back sweeps.
    do_reset();
    m = 8'($urandom_range(1, 255));
    ch_mask = m;
    start_log.delete();
    en = 1'b1;
    for (int s = 0; s < 12; s++) begin
      wait_evt($sformatf("rnd%0d_done", s), 1'b1, 2000);
      m_next = 8'($urandom_range(1, 255));
      ch_mask = m_next;
      got = start_log;
      start_log.delete();
      check_seq($sformatf("rnd%0d_seq", s), m, got);
      check_all($sformatf("rnd%0d", s));
      m = m_next;
    end

    if (IIR) begin
      do_reset();
      ch_mask = 8'h08;
      en = 1'b1;
      q_res = '{12'h400};
      wait_evt("iir_first", 1'b1, 400);
      rd_ch = 3'd3; #1; chk("iir_rd3_a", rd_data, 12'h400);
      q_res = '{12'h800};
      wait_evt("iir_second", 1'b1, 400);
      rd_ch = 3'd3; #1; chk("iir_rd3_b", rd_data, 12'h500);
    end

    chk("single_cycle_pulses", dbl_pulse, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
